// File: rtl/adder_and_subtractor_64bit_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
package adder_and_subtractor_64bit_pkg;
  localparam int   DEFAULT_WIDTH = 64;
  localparam logic MODE_ADD      = 1'b0;
  localparam logic MODE_SUB      = 1'b1;
endpackage

// File: rtl/adder_and_subtractor_64bit_full_adder.sv
// One ripple stage: gate-level full adder (XOR2/AND2/OR2).
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  logic p, g, pc;

  assign p    = A ^ B;
  assign g    = A & B;
  assign pc   = p & Cin;
  assign Sum  = p ^ Cin;
  assign Cout = g | pc;
endmodule

// File: rtl/adder_and_subtractor_64bit.sv
// Registered add/subtract: Cin selects A+B or A-B via B inversion plus carry-in.
module adder_and_subtractor_64bit
  import adder_and_subtractor_64bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ovf
);
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] out_d, out_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Cin doubles as the +1 of the two's-complement negation in subtract mode.
  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_x[i] = B[i] ^ Cin;
    full_adder_1bit u_fa (
      .A    (A[i]),
      .B    (b_x[i]),
      .Cin  (carry[i]),
      .Sum  (sum[i]),
      .Cout (carry[i+1])
    );
  end

  always_comb begin
    out_d  = out_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (En) begin
      out_d  = sum;
      cout_d = carry[WIDTH];
      ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      out_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Out  = out_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_adder_and_subtractor_64bit.sv
// Directed and random checks of the registered adder/subtractor.
module tb_adder_and_subtractor_64bit;
  import adder_and_subtractor_64bit_pkg::*;

  localparam int W = 64;

  logic         CLK;
  logic         Reset;
  logic         En;
  logic [W-1:0] A, B;
  logic         Cin;
  logic [W-1:0] Out;
  logic         Cout, Ovf;

  int n_chk  = 0;
  int n_fail = 0;

  adder_and_subtractor_64bit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .En    (En),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Out   (Out),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eo, input logic ec, input logic ev);
    chk({tag, ".out"},  Out, eo);
    chk({tag, ".cout"}, {{(W-1){1'b0}}, Cout}, {{(W-1){1'b0}}, ec});
    chk({tag, ".ovf"},  {{(W-1){1'b0}}, Ovf},  {{(W-1){1'b0}}, ev});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    Cin = m; A = a; B = b;
  endtask

  // Independent reference built on the native '+' operator.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       output logic [W-1:0] s, output logic c, output logic v);
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx   = m ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, m};
    s    = full[W-1:0];
    c    = full[W];
    v    = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
  endtask

  initial begin
    logic [W-1:0] es, ra, rb;
    logic         ec, ev, rm;

    Reset = 1'b0; En = 1'b1;
    apply(MODE_ADD, 64'd5, 64'd3);
    tick();
    chk_all("reset", 64'd0, 1'b0, 1'b0);

    Reset = 1'b1;
    tick();
    chk_all("add_5_3", 64'd8, 1'b0, 1'b0);

    apply(MODE_SUB, 64'd0, 64'd7);
    tick();
    chk_all("neg_7", 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0);

    apply(MODE_SUB, 64'd7, 64'd7);
    tick();
    chk_all("sub_7_7", 64'd0, 1'b1, 1'b0);

    apply(MODE_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    chk_all("pos_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    apply(MODE_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    chk_all("wrap", 64'd0, 1'b1, 1'b0);

    apply(MODE_SUB, 64'h8000_0000_0000_0000, 64'd1);
    tick();
    chk_all("neg_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    apply(MODE_ADD, 64'd5, 64'd3);
    tick();
    chk_all("reload8", 64'd8, 1'b0, 1'b0);

    En = 1'b0;
    apply(MODE_ADD, 64'd1, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("hold", 64'd8, 1'b0, 1'b0);
    end

    // Operand changes between edges must not leak through.
    En = 1'b1;
    apply(MODE_ADD, 64'd2, 64'd2);
    #2;
    chk_all("mid_cycle", 64'd8, 1'b0, 1'b0);
    apply(MODE_SUB, 64'd0, 64'd1);
    #1;
    chk_all("mid_cycle2", 64'd8, 1'b0, 1'b0);
    apply(MODE_ADD, 64'd2, 64'd2);
    tick();
    chk_all("add_2_2", 64'd4, 1'b0, 1'b0);

    Reset = 1'b0; En = 1'b1;
    apply(MODE_ADD, 64'd9, 64'd1);
    tick();
    chk_all("rst_prio", 64'd0, 1'b0, 1'b0);

    Reset = 1'b1;
    tick();
    chk_all("post_rst", 64'd10, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra[W-1 -: 8] = 8'h7F;
      if (i % 10 == 1) rb[W-1 -: 8] = 8'h80;
      apply(rm, ra, rb);
      model(ra, rb, rm, es, ec, ev);
      tick();
      chk({"rand", $sformatf("%0d", i)}, Out, es);
      chk({"rand_flags", $sformatf("%0d", i)}, {{(W-2){1'b0}}, Cout, Ovf}, {{(W-2){1'b0}}, ec, ev});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
